// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the single-ported Memory between the CPU and a debug requester
// The CPU has priority; a debug access waits for an idle cycle or forces one CPU stall.
module mem_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_busy,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_drive,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_wait_cnt;
  logic                r_hold_we;
  logic [ADDR_W-1:0]   r_hold_addr;
  logic [DATA_W-1:0]   r_hold_wdata;
  logic [DATA_W-1:0]   r_dbg_rdata;

  logic                w_starved;
  logic                w_dbg_access;
  logic                w_accept;

  // Reset suppresses the debug access combinationally, even if the state is still PEND.
  assign w_starved    = (r_wait_cnt >= 8'(STARVE_LIMIT));
  assign w_dbg_access = (r_state == S_PEND) && !RST && (!cpu_cs || w_starved);
  assign w_accept     = (r_state == S_IDLE) && dbg_req;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (dbg_req) w_state_nxt = S_PEND;
      S_PEND: if (w_dbg_access) w_state_nxt = S_ACK;
      S_ACK:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= 8'd0;
      r_hold_we    <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_hold_we    <= dbg_we;
        r_hold_addr  <= dbg_addr;
        r_hold_wdata <= dbg_wdata;
        r_wait_cnt   <= 8'd0;
      end else if ((r_state == S_PEND) && !w_dbg_access) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      if (w_dbg_access && !r_hold_we) begin
        r_dbg_rdata <= mem_rdata;
      end
    end
  end

  assign mem_cs    = w_dbg_access ? 1'b1         : cpu_cs;
  assign mem_we    = w_dbg_access ? r_hold_we    : cpu_we;
  assign mem_addr  = w_dbg_access ? r_hold_addr  : cpu_addr;
  assign mem_wdata = w_dbg_access ? r_hold_wdata : cpu_wdata;
  assign mem_drive = mem_cs & mem_we;

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = w_dbg_access && cpu_cs;
  assign dbg_busy  = (r_state != S_IDLE);
  assign dbg_ack   = (r_state == S_ACK);
  assign dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a request-level model
// A bench-side array plays the Memory; a separate reference array tracks what it must hold.
module tb_mem_arbiter;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int LIMIT = 15;

  logic          CLK = 1'b0;
  logic          RST;
  logic          cpu_cs, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          dbg_busy, dbg_ack;
  logic          mem_cs, mem_we, mem_drive;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] phys_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem  [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_busy(dbg_busy), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_drive(mem_drive), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = phys_mem[mem_addr];
  always @(posedge CLK) if (mem_cs && mem_we) phys_mem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: one outstanding request with a count of CPU-busy cycles it has waited.
  bit            m_pend, m_ack, m_we;
  int            m_waited;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always @(negedge CLK) begin
    bit            e_acc;
    logic          e_cs, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    e_acc   = m_pend && !RST && (!cpu_cs || m_waited >= LIMIT);
    e_cs    = e_acc ? 1'b1    : cpu_cs;
    e_we    = e_acc ? m_we    : cpu_we;
    e_addr  = e_acc ? m_addr  : cpu_addr;
    e_wdata = e_acc ? m_wdata : cpu_wdata;
    if (chk_en) begin
      chk("cpu_stall", cpu_stall, e_acc && cpu_cs);
      chk("dbg_busy", dbg_busy, m_pend || m_ack);
      chk("dbg_ack", dbg_ack, m_ack);
      chk("dbg_rdata", dbg_rdata, m_rdata);
      chk("mem_cs", mem_cs, e_cs);
      chk("mem_addr", mem_addr, e_addr);
      if (e_cs) begin
        chk("mem_we", mem_we, e_we);
        chk("mem_drive", mem_drive, e_cs && e_we);
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        else      chk("cpu_rdata", cpu_rdata, ref_mem[e_addr]);
      end
    end
    if (e_acc && !m_we) m_rdata = ref_mem[m_addr];
    if (e_cs && e_we) ref_mem[e_addr] = e_wdata;
    if (RST) begin
      m_pend = 0; m_ack = 0; m_waited = 0;
      m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_ack) begin
      m_ack = 0;
    end else if (m_pend) begin
      if (e_acc) begin m_pend = 0; m_ack = 1; end
      else m_waited++;
    end else if (dbg_req) begin
      m_pend = 1; m_waited = 0;
      m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata;
    end
  end

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic mid();
    @(negedge CLK); #1;
  endtask

  task automatic idle_in();
    RST = 0; cpu_cs = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  int acks;
  int pct;
  int busy_pct [8] = '{20, 95, 100, 60, 0, 100, 40, 85};

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      phys_mem[i] = $urandom;
      ref_mem[i]  = phys_mem[i];
    end
    phys_mem[5]  = 32'hDEADBEEF; ref_mem[5]  = 32'hDEADBEEF;
    phys_mem[20] = 32'hA5A50020; ref_mem[20] = 32'hA5A50020;
    idle_in();
    RST = 1;
    next_cycle();
    chk_en = 1;
    next_cycle();
    RST = 0;
    mid();
    chk("reset_busy", dbg_busy, 1'b0);
    chk("reset_ack", dbg_ack, 1'b0);
    chk("reset_stall", cpu_stall, 1'b0);
    chk("reset_rdata", dbg_rdata, 32'h0);
    next_cycle();

    // idle CPU read
    dbg_req = 1; dbg_addr = 7'd5; dbg_we = 0;
    next_cycle(); dbg_req = 0;
    mid();
    chk("rd_c1_mem_cs", mem_cs, 1'b1);
    chk("rd_c1_mem_addr", mem_addr, 32'd5);
    chk("rd_c1_busy", dbg_busy, 1'b1);
    chk("rd_c1_stall", cpu_stall, 1'b0);
    next_cycle(); mid();
    chk("rd_c2_ack", dbg_ack, 1'b1);
    chk("rd_c2_busy", dbg_busy, 1'b1);
    chk("rd_c2_rdata", dbg_rdata, 32'hDEADBEEF);
    next_cycle();

    // debug write then CPU read
    dbg_req = 1; dbg_we = 1; dbg_addr = 7'd9; dbg_wdata = 32'h12345678;
    next_cycle(); dbg_req = 0; dbg_we = 0;
    mid();
    chk("wr_c1_drive", mem_drive, 1'b1);
    chk("wr_c1_addr", mem_addr, 32'd9);
    next_cycle(); mid();
    chk("wr_c2_ack", dbg_ack, 1'b1);
    chk("wr_c2_drive", mem_drive, 1'b0);
    chk("wr_c2_rdata_kept", dbg_rdata, 32'hDEADBEEF);
    next_cycle();
    cpu_cs = 1; cpu_addr = 7'd9;
    mid();
    chk("wr_cpu_rdata", cpu_rdata, 32'h12345678);
    chk("wr_cpu_drive", mem_drive, 1'b0);
    next_cycle(); idle_in();
    next_cycle();

    // starvation with CPU busy every cycle
    cpu_cs = 1; cpu_addr = 7'd40; dbg_req = 1; dbg_addr = 7'd3;
    next_cycle(); dbg_req = 0;
    for (int k = 1; k <= 17; k++) begin
      cpu_addr = AW'(40 + k);
      mid();
      chk($sformatf("starve_stall_c%0d", k), cpu_stall, (k == 16));
      chk($sformatf("starve_addr_c%0d", k), mem_addr, (k == 16) ? 32'd3 : 32'(40 + k));
      chk($sformatf("starve_ack_c%0d", k), dbg_ack, (k == 17));
      next_cycle();
    end
    idle_in(); next_cycle();

    // debug access fills the first idle CPU cycle
    cpu_cs = 1; cpu_addr = 7'd60; dbg_req = 1; dbg_addr = 7'd7;
    for (int k = 1; k <= 5; k++) begin
      next_cycle(); dbg_req = 0;
      cpu_cs = (k <= 3);
      mid();
      chk($sformatf("gap_stall_c%0d", k), cpu_stall, 1'b0);
      if (k == 4) chk("gap_addr_c4", mem_addr, 32'd7);
      chk($sformatf("gap_ack_c%0d", k), dbg_ack, (k == 5));
    end
    next_cycle(); idle_in(); next_cycle();

    // requests while busy and with the ack are dropped
    acks = 0;
    for (int k = 0; k <= 5; k++) begin
      dbg_req  = (k <= 3);
      dbg_addr = (k == 3) ? 7'd13 : AW'(11 + k);
      mid();
      if (k >= 1 && k <= 3) acks += int'(dbg_ack);
      if (k == 1) chk("drop_c1_addr", mem_addr, 32'd11);
      if (k == 3) chk("drop_c3_busy", dbg_busy, 1'b0);
      if (k == 4) chk("drop_c4_addr", mem_addr, 32'd13);
      if (k == 5) chk("drop_c5_ack", dbg_ack, 1'b1);
      next_cycle();
    end
    chk("drop_ack_count", acks, 32'd1);
    idle_in(); next_cycle();

    // reset while PEND drops a debug write
    cpu_cs = 1; cpu_addr = 7'd50; dbg_req = 1; dbg_we = 1; dbg_addr = 7'd20;
    dbg_wdata = 32'h0BADF00D;
    next_cycle(); dbg_req = 0; dbg_we = 0;
    next_cycle(); mid();
    chk("rst_pend_busy", dbg_busy, 1'b1);
    next_cycle();
    RST = 1;
    mid();
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_addr", mem_addr, 32'd50);
    next_cycle();
    RST = 0; cpu_cs = 0;
    mid();
    chk("rst_after_busy", dbg_busy, 1'b0);
    chk("rst_after_ack", dbg_ack, 1'b0);
    next_cycle();
    cpu_cs = 1; cpu_addr = 7'd20;
    mid();
    chk("rst_no_write", cpu_rdata, 32'hA5A50020);
    chk("rst_no_ack", dbg_ack, 1'b0);
    next_cycle(); idle_in();

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      pct       = busy_pct[(i / 500) % 8];
      RST       = ($urandom_range(0, 299) == 0);
      cpu_cs    = ($urandom_range(0, 99) < pct);
      cpu_we    = ($urandom_range(0, 3) == 0);
      cpu_addr  = AW'($urandom);
      cpu_wdata = $urandom;
      dbg_req   = ($urandom_range(0, 99) < 30);
      dbg_we    = $urandom_range(0, 1);
      dbg_addr  = AW'($urandom);
      dbg_wdata = $urandom;
      next_cycle();
    end
    idle_in();
    next_cycle(); next_cycle();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported instruction/data Memory between the MIPS CPU and a debug requester (board-level memory inspector driven from switches/buttons). The CPU has absolute priority. Debug accesses use idle memory cycles, and if the CPU occupies the memory too long, the arbiter forces a one-cycle CPU stall. The block sits between the CPU, the Memory, and the debug logic in the top level. The top level converts the unidirectional data ports to the Memory's tri-state bus using `mem_drive`.

## Interface
- `ADDR_W`, 7: word address width.
- `DATA_W`, 32: data width.
- `STARVE_LIMIT`, 15: CPU-busy cycles a pending debug request tolerates before a forced stall; legal range 1..255.

- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `cpu_cs`  in  1  CPU memory request.
- `cpu_we`  in  1  CPU write enable.
- `cpu_addr`  in  ADDR_W  CPU word address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_rdata`  out  DATA_W  read data to CPU (combinational from `mem_rdata`).
- `cpu_stall`  out  1  CPU must hold its request and state this cycle.
- `dbg_req`  in  1  one-cycle request pulse.
- `dbg_we`  in  1  debug write enable, sampled with `dbg_req`.
- `dbg_addr`  in  ADDR_W  debug address, sampled with `dbg_req`.
- `dbg_wdata`  in  DATA_W  debug write data, sampled with `dbg_req`.
- `dbg_busy`  out  1  high whenever state ≠ IDLE.
- `dbg_ack`  out  1  one-cycle completion pulse.
- `dbg_rdata`  out  DATA_W  registered read result; valid from `dbg_ack` until the next read completes.
- `mem_cs`  out  1  to Memory CS.
- `mem_we`  out  1  to Memory WE.
- `mem_addr`  out  ADDR_W  to Memory Address.
- `mem_wdata`  out  DATA_W  value the top level drives onto the memory bus.
- `mem_drive`  out  1  top level enables the bus driver (`mem_cs & mem_we`).
- `mem_rdata`  in  DATA_W  memory bus value (combinational read).

## Operation
- The FSM has three states:
  - **IDLE**: when `dbg_req`=1, latch `dbg_we`, `dbg_addr`, `dbg_wdata` into holding registers, clear `wait_cnt`, then go to PEND.
  - **PEND**, debug access this cycle when `cpu_cs`=0:
    - Route the holding registers to the `mem_*` outputs.
    - On a read, capture `mem_rdata` into `dbg_rdata` at the clock edge.
    - On a write, the Memory writes at that clock edge.
    - Next state is ACK.
  - **PEND**, `cpu_cs`=1 and `wait_cnt` < `STARVE_LIMIT`: pass the CPU through, increment `wait_cnt`, stay in PEND.
  - **PEND**, `cpu_cs`=1 and `wait_cnt` = `STARVE_LIMIT`: assert `cpu_stall`, perform the debug access as above, go to ACK. The CPU retries its access the following cycle.
  - **ACK**: `dbg_ack`=1 for exactly one cycle, then go to IDLE.
- In IDLE, ACK, and CPU-pass-through cycles: `mem_cs`=`cpu_cs`, `mem_we`=`cpu_we`, `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`.
- `cpu_rdata` = `mem_rdata` at all times. The CPU ignores it while `cpu_stall`=1.
- `dbg_req` pulses arriving while `dbg_busy`=1 are ignored; they are neither queued nor acknowledged.
- `dbg_rdata` is unchanged by debug writes.
- `wait_cnt` is 8 bits. It is only compared, never wraps, and is cleared on every accept.

## Timing
- Reset values:
  - State = IDLE.
  - `dbg_busy`=0, `dbg_ack`=0, `cpu_stall`=0.
  - `dbg_rdata`=0, holding registers = 0, `wait_cnt`=0.
- While `RST`=1, `mem_*` follow the CPU pass-through. No debug access and no stall occur, even if the state was PEND; the pending request is dropped without an ack.
- Latency, request pulse at cycle 0 with the CPU idle:
  - Access in cycle 1.
  - `dbg_ack` in cycle 2.
  - `dbg_busy` high in cycles 1–2.
- Worst case with the CPU busy every cycle:
  - Access in cycle 1+`STARVE_LIMIT`.
  - `dbg_ack` in cycle 2+`STARVE_LIMIT`.
  - Exactly one stall cycle.
- `dbg_req` in the same cycle as `dbg_ack` is ignored, because the state is still ACK. The earliest re-accept is the cycle after `dbg_ack`.
- `cpu_stall` is combinational from state, `cpu_cs`, and `wait_cnt`. It is never high outside PEND.

## Test plan
- Idle CPU read: mem[5]=0xDEADBEEF, `dbg_req` with addr 5, `cpu_cs`=0 → `mem_cs`=1 and `mem_addr`=5 in cycle 1; `dbg_ack` in cycle 2 with `dbg_rdata`=0xDEADBEEF; `cpu_stall` never asserted.
- Debug write then CPU read: debug write 0x12345678 to addr 9 → after `dbg_ack`, a CPU read of addr 9 returns 0x12345678 on `cpu_rdata`; `mem_drive` high only during the debug access cycle.
- Starvation: `cpu_cs`=1 every cycle, `STARVE_LIMIT`=15, `dbg_req` at cycle 0 → `cpu_stall`=1 only in cycle 16, with the debug address on `mem_addr`; `dbg_ack` in cycle 17; CPU addresses pass through in cycles 1–15.
- Gap use: CPU busy in cycles 1–3 and idle in cycle 4 → debug access in cycle 4, `dbg_ack` in cycle 5, no stall.
- Dropped requests: second `dbg_req` while busy, and another in the same cycle as `dbg_ack` → exactly one ack; a new `dbg_req` on the next cycle is accepted.
- Reset mid-PEND: `RST` asserted while PEND with `cpu_cs`=1 → no ack, no stall, no debug write; after `RST` deasserts, state is IDLE and `dbg_busy`=0.
